// File: rtl/task_5_answer_packer_if.sv
// Result-in / answer-out bundle between the CORDIC stage, the packer and the task manager.
interface task_5_answer_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_data_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_input_last;
  logic                  i_tmanager_ready;
  logic                  o_tanswer_ready;
  logic [DATA_WIDTH-1:0] o_tdata;
  logic                  o_tanswer_data_last;
  logic [11:0]           o_packet_size_in_bytes;
  logic                  o_overflow;

  modport slave (
    input  i_data_valid, i_data, i_input_last, i_tmanager_ready,
    output o_tanswer_ready, o_tdata, o_tanswer_data_last, o_packet_size_in_bytes, o_overflow
  );
  modport master (
    output i_data_valid, i_data, i_input_last, i_tmanager_ready,
    input  o_tanswer_ready, o_tdata, o_tanswer_data_last, o_packet_size_in_bytes, o_overflow
  );
endinterface

// File: rtl/task_5_answer_packer.sv
// Buffers CORDIC results and replays them as one answer packet once the pipeline drains.
// Optional build macro TASK5_ANSWER_BYTESWAP_EN byte-reverses each presented answer word.
module task_5_answer_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int DRAIN_CYCLES = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  task_5_answer_packer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {COLLECT, DRAIN, READY, SEND} state_t;

  state_t                state_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [7:0]            drain_q;
  logic                  tready_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  last_q;
  logic [11:0]           size_q;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  full_d;
  logic                  wr_d;
  logic [PW-1:0]         nxt_ptr_d;

  function automatic logic [DATA_WIDTH-1:0] present(input logic [DATA_WIDTH-1:0] w);
`ifdef TASK5_ANSWER_BYTESWAP_EN
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < DATA_WIDTH/8; b++)
      r[8*b +: 8] = w[DATA_WIDTH-8-8*b +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  assign full_d    = (count_q == CW'(DEPTH));
  assign wr_d      = bus.i_data_valid && !full_d && (state_q == COLLECT || state_q == DRAIN);
  assign nxt_ptr_d = rd_ptr_q + 1'b1;

  // Buffer needs no reset: count_q alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_d) mem_q[count_q[PW-1:0]] <= bus.i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= COLLECT;
      count_q  <= '0;
      rd_ptr_q <= '0;
      drain_q  <= '0;
      tready_q <= 1'b0;
      tdata_q  <= '0;
      last_q   <= 1'b0;
      size_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_d) count_q <= count_q + 1'b1;
      if (bus.i_data_valid && !wr_d) ovf_q <= 1'b1;
      case (state_q)
        COLLECT: begin
          if (bus.i_input_last) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          // Any arriving result, kept or dropped, restarts the drain window.
          if (bus.i_data_valid) begin
            drain_q <= '0;
          end else if (drain_q == 8'(DRAIN_CYCLES - 1)) begin
            if (count_q != '0) begin
              state_q  <= READY;
              tready_q <= 1'b1;
              size_q   <= 12'({count_q, 2'b00});
              rd_ptr_q <= '0;
              tdata_q  <= present(mem_q[0]);
            end else begin
              state_q <= COLLECT;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        READY: begin
          if (bus.i_tmanager_ready) begin
            state_q <= SEND;
            last_q  <= (count_q == CW'(1));
          end
        end
        SEND: begin
          if (bus.i_tmanager_ready) begin
            if (last_q) begin
              state_q  <= COLLECT;
              count_q  <= '0;
              rd_ptr_q <= '0;
              ovf_q    <= 1'b0;
              tready_q <= 1'b0;
              last_q   <= 1'b0;
              size_q   <= '0;
              tdata_q  <= '0;
            end else begin
              rd_ptr_q <= nxt_ptr_d;
              tdata_q  <= present(mem_q[nxt_ptr_d]);
              last_q   <= (CW'(nxt_ptr_d) == count_q - 1'b1);
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.o_tanswer_ready        = tready_q;
  assign bus.o_tdata                = tdata_q;
  assign bus.o_tanswer_data_last    = last_q;
  assign bus.o_packet_size_in_bytes = size_q;
  assign bus.o_overflow             = ovf_q;
endmodule

// File: tb/tb_task_5_answer_packer.sv
// Directed bench: main instance (DEPTH 256) and a DEPTH 4 instance share one stimulus.
module tb_task_5_answer_packer;
  logic        clk, rst;
  logic        dv, il, tr;
  logic [31:0] din;
  int          n_tests, n_fail;

  task_5_answer_packer_if #(.DATA_WIDTH(32)) ia();
  task_5_answer_packer_if #(.DATA_WIDTH(32)) ib();

  assign ia.i_data_valid = dv;  assign ib.i_data_valid = dv;
  assign ia.i_data = din;       assign ib.i_data = din;
  assign ia.i_input_last = il;  assign ib.i_input_last = il;
  assign ia.i_tmanager_ready = tr; assign ib.i_tmanager_ready = tr;

  task_5_answer_packer #(.DATA_WIDTH(32), .DEPTH(256), .DRAIN_CYCLES(32))
    dut_a (.i_clk(clk), .i_rst(rst), .bus(ia));
  task_5_answer_packer #(.DATA_WIDTH(32), .DEPTH(4), .DRAIN_CYCLES(32))
    dut_b (.i_clk(clk), .i_rst(rst), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef TASK5_ANSWER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] w);
    dv = 1'b1; din = w; tick(); dv = 1'b0;
  endtask

  task automatic close_pkt();
    il = 1'b1; tick(); il = 1'b0;
  endtask

  task automatic wait_rdy(input int max, output int n);
    n = 0;
    while (ia.o_tanswer_ready !== 1'b1 && n < max) begin tick(); n++; end
    chk("rdy_timeout", {31'd0, ia.o_tanswer_ready}, 32'd1);
  endtask

  logic [31:0] w4 [4]  = '{32'h00010002, 32'h00020003, 32'h00030004, 32'h00040005};
  logic [31:0] w6 [6]  = '{32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004, 32'hB0000005, 32'hB0000006};
  logic [31:0] w3 [3]  = '{32'h0A0A0001, 32'h0B0B0002, 32'h0C0C0003};
  logic        bp [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int n, idx;
    logic seen;
    n_tests = 0; n_fail = 0;
    rst = 1'b0; dv = 1'b0; il = 1'b0; tr = 1'b0; din = '0;
    tick(); tick();
    chk("rst_rdy",  {31'd0, ia.o_tanswer_ready}, 0);
    chk("rst_data", ia.o_tdata, 0);
    chk("rst_last", {31'd0, ia.o_tanswer_data_last}, 0);
    chk("rst_size", {20'd0, ia.o_packet_size_in_bytes}, 0);
    chk("rst_ovf",  {31'd0, ia.o_overflow}, 0);
    rst = 1'b1; tick();

    // Overflow on the DEPTH 4 instance
    for (int i = 0; i < 6; i++) push(w6[i]);
    close_pkt();
    wait_rdy(60, n);
    chk("ovf_size", {20'd0, ib.o_packet_size_in_bytes}, 16);
    chk("ovf_flag", {31'd0, ib.o_overflow}, 1);
    chk("ovf_a_size", {20'd0, ia.o_packet_size_in_bytes}, 24);
    tr = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("ovf_word", ib.o_tdata, ew(w6[i]));
      chk("ovf_last", {31'd0, ib.o_tanswer_data_last}, (i == 3) ? 1 : 0);
      chk("ovf_hold", {31'd0, ib.o_overflow}, 1);
      tick();
    end
    chk("ovf_clr", {31'd0, ib.o_overflow}, 0);
    chk("ovf_rdy_lo", {31'd0, ib.o_tanswer_ready}, 0);
    tick(); tick();
    chk("ovf_a_done", {31'd0, ia.o_tanswer_ready}, 0);
    tr = 1'b0;

    // Basic packet
    for (int i = 0; i < 4; i++) push(w4[i]);
    close_pkt();
    wait_rdy(60, n);
    chk("bas_size", {20'd0, ia.o_packet_size_in_bytes}, 16);
    chk("bas_ovf", {31'd0, ia.o_overflow}, 0);
    chk("bas_ready_word", ia.o_tdata, ew(w4[0]));
    tr = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("bas_word", ia.o_tdata, ew(w4[i]));
      chk("bas_last", {31'd0, ia.o_tanswer_data_last}, (i == 3) ? 1 : 0);
      tick();
    end
    chk("bas_rdy_lo", {31'd0, ia.o_tanswer_ready}, 0);
    chk("bas_last_lo", {31'd0, ia.o_tanswer_data_last}, 0);
    tr = 1'b0;

    // Backpressure in SEND
    for (int i = 0; i < 3; i++) push(w3[i]);
    close_pkt();
    wait_rdy(60, n);
    tr = 1'b1; tick();
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      tr = bp[i];
      chk("bp_word", ia.o_tdata, ew(w3[idx]));
      chk("bp_last", {31'd0, ia.o_tanswer_data_last}, (idx == 2) ? 1 : 0);
      tick();
      if (bp[i]) idx++;
    end
    chk("bp_done", {31'd0, ia.o_tanswer_ready}, 0);
    tr = 1'b0;

    // Late result 10 cycles after input_last
    close_pkt();
    for (int i = 0; i < 9; i++) tick();
    push(32'hCAFE0001);
    wait_rdy(60, n);
    chk("late_latency", n + 1, 33);
    chk("late_size", {20'd0, ia.o_packet_size_in_bytes}, 4);
    tr = 1'b1; tick();
    chk("late_word", ia.o_tdata, ew(32'hCAFE0001));
    chk("late_last", {31'd0, ia.o_tanswer_data_last}, 1);
    tick(); tr = 1'b0;
    chk("late_done", {31'd0, ia.o_tanswer_ready}, 0);

    // Empty packet, then a byte-order check packet
    close_pkt();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin seen |= ia.o_tanswer_ready; tick(); end
    chk("empty_rdy", {31'd0, seen}, 0);
    push(32'h11223344);
    close_pkt();
    wait_rdy(60, n);
    chk("swap_size", {20'd0, ia.o_packet_size_in_bytes}, 4);
    tr = 1'b1; tick();
    chk("swap_word", ia.o_tdata, ew(32'h11223344));
    tick(); tr = 1'b0;

    // Reset during SEND after two beats
    for (int i = 0; i < 5; i++) push(32'hD0000000 + i);
    close_pkt();
    wait_rdy(60, n);
    tr = 1'b1; tick(); tick(); tick();
    chk("mid_word", ia.o_tdata, ew(32'hD0000002));
    rst = 1'b0; #1;
    chk("arst_rdy",  {31'd0, ia.o_tanswer_ready}, 0);
    chk("arst_data", ia.o_tdata, 0);
    chk("arst_last", {31'd0, ia.o_tanswer_data_last}, 0);
    chk("arst_size", {20'd0, ia.o_packet_size_in_bytes}, 0);
    chk("arst_ovf",  {31'd0, ia.o_overflow}, 0);
    tr = 1'b0;
    tick(); rst = 1'b1; tick();
    push(32'h00000005);
    close_pkt();
    wait_rdy(60, n);
    chk("post_size", {20'd0, ia.o_packet_size_in_bytes}, 4);
    chk("post_word", ia.o_tdata, ew(32'h00000005));
    tr = 1'b1; tick();
    chk("post_last", {31'd0, ia.o_tanswer_data_last}, 1);
    tick(); tr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/task_5_answer_packer.md
# task_5_answer_packer

Downstream stage of the task 5 CORDIC datapath. Collects 32-bit CORDIC result words (`{X,1'b0,Y,1'b0}`) into a local buffer. After the upstream input packet has ended and the CORDIC pipeline has drained, it offers the buffered results to the task manager as one answer packet. The packet goes out as a stream of 32-bit words with a last flag and a byte-size field.

## Interface
Parameters:
- `DATA_WIDTH`, 32: result/answer word width.
- `DEPTH`, 256: buffer depth in words; legal range 1..1023.
- `DRAIN_CYCLES`, 32: idle cycles required after input end before the packet is closed; must be ≥ CORDIC latency; legal range 1..255.

Ports:
- `i_clk` in 1: the block's single clock.
- `i_rst` in 1: reset; asynchronous, active-low.
- `i_data_valid` in 1: result word present on `i_data` this cycle.
- `i_data` in `DATA_WIDTH`: CORDIC result word.
- `i_input_last` in 1: single-cycle pulse; upstream accepted the final input byte of the packet.
- `i_tmanager_ready` in 1: task manager accepts an answer word this cycle.
- `o_tanswer_ready` out 1: answer packet available; high in READY and SEND.
- `o_tdata` out `DATA_WIDTH`: current answer word.
- `o_tanswer_data_last` out 1: `o_tdata` is the final word of the packet.
- `o_packet_size_in_bytes` out 12: `count*4`; valid while `o_tanswer_ready` is high.
- `o_overflow` out 1: sticky; a result was dropped.

## Operation
- The state machine has four states: COLLECT, DRAIN, READY, SEND. Reset state is COLLECT.
- **COLLECT**
  - Each `i_data_valid` writes `i_data` to `mem[count]` and increments `count`.
  - `i_input_last` moves the FSM to DRAIN and clears the drain counter.
  - If `i_input_last` and `i_data_valid` occur together, the word is written and the transition still occurs.
- **DRAIN**
  - `i_data_valid` writes the word and clears the drain counter.
  - Otherwise the drain counter increments.
  - When the counter reaches `DRAIN_CYCLES-1` with no valid: go to READY if `count>0`, else return to COLLECT with no answer.
- **READY**
  - `o_tanswer_ready=1`, `o_packet_size_in_bytes=count*4`, `rd_ptr=0`, `o_tdata=mem[0]`.
  - `i_tmanager_ready=1` moves the FSM to SEND on the next cycle. No beat is transferred in READY.
- **SEND**
  - A beat transfers on each cycle with `i_tmanager_ready=1`. `o_tdata` holds `mem[rd_ptr]` and the FSM advances `rd_ptr` on each beat.
  - When `i_tmanager_ready=0`, `o_tdata` and `rd_ptr` hold.
  - `o_tanswer_data_last` = (`rd_ptr==count-1`) while in SEND.
  - The beat carrying last moves the FSM to COLLECT. That transition clears `count`, `rd_ptr` and `o_overflow`.
- **Overflow**
  - A valid word is dropped, and `o_overflow` set, when `count==DEPTH` in COLLECT/DRAIN, or when it arrives in READY/SEND.
  - A dropped word in DRAIN still clears the drain counter.
- `i_input_last` in DRAIN, READY or SEND is ignored.
- Arithmetic widths:
  - `count` is `$clog2(DEPTH+1)` bits and never wraps.
  - The byte size is `count` shifted left by 2, zero-extended to 12 bits.

## Timing
- Reset values: `o_tanswer_ready=0`, `o_tdata=0`, `o_tanswer_data_last=0`, `o_packet_size_in_bytes=0`, `o_overflow=0`, `count=0`, FSM=COLLECT.
- Reset asserted mid-packet aborts immediately, discards the buffer, and forces the reset values.
- All outputs are registered. A word written on cycle t is readable in any packet closed at cycle t+1 or later.
- `o_tanswer_ready` rises exactly `DRAIN_CYCLES+1` cycles after the last `i_data_valid` or `i_input_last` pulse, whichever is later.
- Throughput in SEND is one word per cycle with `i_tmanager_ready` held high. An N-word packet leaves READY and completes in N+1 cycles.
- After the last beat, `o_tanswer_ready` and `o_tanswer_data_last` are low on the next cycle, and a new result may be written that same cycle.

## Configuration
- `TASK5_ANSWER_BYTESWAP_EN`
  - Defined: `o_tdata` presents each stored word byte-reversed (`{b0,b1,b2,b3}`).
  - Undefined: `o_tdata` presents the word exactly as received.
  - Buffer contents, sizes and timing are identical in both builds.

## Test plan
- **Basic packet:** 4 results `0x00010002..0x00040005`, then `i_input_last`, then `i_tmanager_ready` held high.
  - `o_packet_size_in_bytes=16`; 4 beats in order; last on beat 4; `o_overflow=0`.
- **Backpressure:** 3-word packet, `i_tmanager_ready` toggled 1,0,0,1,1.
  - Words hold while ready is low.
  - Each word is transferred exactly once.
  - Last accompanies word 3.
- **Late results:** `i_input_last`, then a valid arrives 10 cycles later, with `DRAIN_CYCLES=32`.
  - The word is included.
  - `o_tanswer_ready` rises 33 cycles after that valid.
- **Overflow:** `DEPTH=4`, send 6 results.
  - Size = 16; the first 4 words are output.
  - `o_overflow=1` until the last beat, then 0.
- **Empty and reset cases:**
  - `i_input_last` with no results: no `o_tanswer_ready`; FSM back in COLLECT.
  - Reset asserted in SEND after 2 of 5 beats: all outputs 0 immediately; the next packet starts from empty.
- **Byte swap:** build with `TASK5_ANSWER_BYTESWAP_EN`, send word `0x11223344`.
  - `o_tdata=0x44332211`.
